// File: rtl/pla_dispatch.sv
// pla_dispatch
// ------------
// Instruction dispatcher for a bank of NUM_ACC accelerators. An accepted
// instruction's low OPC_W bits select a channel (opcode 1 -> channel 0, and so
// on). Opcode 0 is a NOP. Opcodes above NUM_ACC are illegal. For a legal
// opcode the selected accelerator is enabled. The dispatcher then waits for
// that channel's read-phase and write-phase done levels. It pulses acc_done,
// then waits for both done levels to drop before it takes the next
// instruction. A watchdog bounds every waiting phase. An illegal opcode or an
// expired watchdog produces an acc_err pulse with a reason in err_code.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   instr_valid  instruction present on 'instruction'
//   instr_ready  dispatcher idle and able to accept (combinational)
//   instruction  instruction word; only bits [OPC_W-1:0] are decoded
//   rd_done      per-channel read-phase complete level
//   wr_done      per-channel write-phase complete level
//   acc_enable   one-hot enable of the selected accelerator (or zero)
//   acc_done     one-cycle pulse: operation finished
//   acc_err      one-cycle pulse: operation aborted
//   err_code     00 none, 01 illegal opcode, 10 read timeout,
//                11 write or release timeout
//   busy         dispatcher not idle (combinational)
//   active_ch    channel of the current or most recent legal operation

module pla_dispatch #(
    parameter int NUM_ACC = 3,
    parameter int OPC_W   = 3,
    parameter int INSTR_W = 32,
    parameter int CH_W    = 2,
    parameter int TIMEOUT = 1024,
    parameter int TMO_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [NUM_ACC-1:0] rd_done,
    input  logic [NUM_ACC-1:0] wr_done,
    output logic [NUM_ACC-1:0] acc_enable,
    output logic               acc_done,
    output logic               acc_err,
    output logic [1:0]         err_code,
    output logic               busy,
    output logic [CH_W-1:0]    active_ch
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERROR,
        S_RELEASE
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_RD_TMO  = 2'b10;
    localparam logic [1:0] ERR_WR_TMO  = 2'b11;

    localparam logic [OPC_W-1:0] LAST_OPC  = OPC_W'(NUM_ACC);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);
    localparam bit               WDOG_ON   = (TIMEOUT != 0);

    state_t               state_q, state_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [NUM_ACC-1:0]   enable_q, enable_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [1:0]           code_q, code_d;
    logic [TMO_W-1:0]     wdog_q, wdog_d;
    logic                 errToIdle_q, errToIdle_d;

    logic [OPC_W-1:0]     opc;
    logic                 opcNop;
    logic                 opcLegal;
    logic [CH_W-1:0]      reqCh;
    logic [NUM_ACC-1:0]   reqOneHot;
    logic [NUM_ACC-1:0]   selOneHot;
    logic                 selRd;
    logic                 selWr;
    logic [TMO_W-1:0]     wdogInc;
    logic                 wdogExpired;
    logic                 unusedInstrBits;

    // Opcode decode. Bits above OPC_W carry no meaning for the dispatcher.
    assign opc       = instruction[OPC_W-1:0];
    assign opcNop    = (opc == '0);
    assign opcLegal  = !opcNop && (opc <= LAST_OPC);
    assign reqCh     = CH_W'(opc - OPC_W'(1));
    assign reqOneHot = NUM_ACC'(1) << reqCh;

    assign unusedInstrBits = ^instruction;

    // Only the latched channel's done levels are ever observed. Masking with
    // a one-hot vector avoids out-of-range indexing when 2**CH_W > NUM_ACC.
    assign selOneHot = NUM_ACC'(1) << ch_q;
    assign selRd     = |(rd_done & selOneHot);
    assign selWr     = |(wr_done & selOneHot);

    // Watchdog: counts cycles spent in the current phase. It saturates
    // instead of wrapping, so a disabled watchdog (TIMEOUT == 0) cannot
    // alias back to a small count. The phase expires on the cycle the
    // incremented count reaches TIMEOUT, so a phase lasts at most TIMEOUT cycles.
    assign wdogInc     = (wdog_q == '1) ? wdog_q : wdog_q + TMO_W'(1);
    assign wdogExpired = WDOG_ON && (wdogInc >= TMO_LIMIT);

    // Next-state and registered-output logic. Pulses default low so they
    // last exactly one cycle. The enable clears whenever DONE or ERROR is
    // entered. errToIdle_d records whether ERROR should skip RELEASE.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        enable_d    = enable_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        code_d      = code_q;
        wdog_d      = wdog_q;
        errToIdle_d = errToIdle_q;

        case (state_q)
            S_IDLE: begin
                if (instr_valid && !opcNop) begin
                    if (opcLegal) begin
                        state_d  = S_READ;
                        ch_d     = reqCh;
                        code_d   = ERR_NONE;
                        enable_d = reqOneHot;
                        wdog_d   = '0;
                    end else begin
                        state_d     = S_ERROR;
                        code_d      = ERR_ILLEGAL;
                        err_d       = 1'b1;
                        enable_d    = '0;
                        errToIdle_d = 1'b1;
                    end
                end
            end

            S_READ: begin
                if (selRd) begin
                    state_d = S_WRITE;
                    wdog_d  = '0;
                end else if (wdogExpired) begin
                    state_d     = S_ERROR;
                    code_d      = ERR_RD_TMO;
                    err_d       = 1'b1;
                    enable_d    = '0;
                    errToIdle_d = 1'b0;
                end else begin
                    wdog_d = wdogInc;
                end
            end

            S_WRITE: begin
                if (selWr) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    enable_d = '0;
                end else if (wdogExpired) begin
                    state_d     = S_ERROR;
                    code_d      = ERR_WR_TMO;
                    err_d       = 1'b1;
                    enable_d    = '0;
                    errToIdle_d = 1'b0;
                end else begin
                    wdog_d = wdogInc;
                end
            end

            S_DONE: begin
                state_d = S_RELEASE;
                wdog_d  = '0;
            end

            // An illegal opcode never started the accelerator, and a release
            // timeout has already waited, so both of those return straight to IDLE.
            S_ERROR: begin
                if (errToIdle_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RELEASE;
                    wdog_d  = '0;
                end
            end

            // Hold off new work until the channel's level-done signals drop,
            // otherwise a stale level would complete the next operation at once.
            S_RELEASE: begin
                if (!selRd && !selWr) begin
                    state_d = S_IDLE;
                end else if (wdogExpired) begin
                    state_d     = S_ERROR;
                    code_d      = ERR_WR_TMO;
                    err_d       = 1'b1;
                    enable_d    = '0;
                    errToIdle_d = 1'b1;
                end else begin
                    wdog_d = wdogInc;
                end
            end

            default: begin
                state_d  = S_IDLE;
                enable_d = '0;
            end
        endcase
    end

    // State and output registers. Reset clears everything silently,
    // including any operation in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            enable_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= ERR_NONE;
            wdog_q      <= '0;
            errToIdle_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            enable_q    <= enable_d;
            done_q      <= done_d;
            err_q       <= err_d;
            code_q      <= code_d;
            wdog_q      <= wdog_d;
            errToIdle_q <= errToIdle_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign acc_enable  = enable_q;
    assign acc_done    = done_q;
    assign acc_err     = err_q;
    assign err_code    = code_q;
    assign active_ch   = ch_q;

endmodule

// File: tb/tb_pla_dispatch.sv
// tb_pla_dispatch
// ---------------
// Scoreboard bench for pla_dispatch with NUM_ACC=3 and TIMEOUT=8. Each
// operation is described by when the selected channel's done levels rise and
// fall. A small reference model turns that description into the expected
// pulse, its cycle, its err_code, and the step at which the dispatcher returns
// to idle. A separate monitor pops the expected pulses as the DUT shows them.

module tb_pla_dispatch;

    localparam int NUM_ACC = 3;
    localparam int OPC_W   = 3;
    localparam int INSTR_W = 32;
    localparam int CH_W    = 2;
    localparam int TMO     = 8;
    localparam int TMO_W   = 16;
    localparam int NEVER   = 1000;

    logic               clk;
    logic               reset;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instruction;
    logic [NUM_ACC-1:0] rd_done;
    logic [NUM_ACC-1:0] wr_done;
    logic [NUM_ACC-1:0] acc_enable;
    logic               acc_done;
    logic               acc_err;
    logic [1:0]         err_code;
    logic               busy;
    logic [CH_W-1:0]    active_ch;

    pla_dispatch #(
        .NUM_ACC(NUM_ACC),
        .OPC_W  (OPC_W),
        .INSTR_W(INSTR_W),
        .CH_W   (CH_W),
        .TIMEOUT(TMO),
        .TMO_W  (TMO_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instruction(instruction),
        .rd_done    (rd_done),
        .wr_done    (wr_done),
        .acc_enable (acc_enable),
        .acc_done   (acc_done),
        .acc_err    (acc_err),
        .err_code   (err_code),
        .busy       (busy),
        .active_ch  (active_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit              isErr;
        logic [1:0]      code;
        logic [CH_W-1:0] ch;
        int              cyc;
    } pulse_t;

    // kind: 0 no pulse, 1 done pulse, 2 error pulse. Steps count edges after
    // the accepting edge (step 0 = the accepting edge itself).
    typedef struct {
        int         kind;
        logic [1:0] code;
        int         pulse;
        int         relPulse;
        int         d;
        int         endStep;
        int         enChk;
    } plan_t;

    pulse_t          expQ[$];
    pulse_t          monEntry;
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    bit              monOn = 1'b0;
    logic [1:0]      mdlErr = 2'b00;
    logic [CH_W-1:0] mdlCh = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (monOn) begin
            checkOutput("enable_onehot0", 32'($onehot0(acc_enable)), 32'd1);
            if (acc_done || acc_err) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_pulse", {acc_done, acc_err}, 2'b00);
                end else begin
                    monEntry = expQ.pop_front();
                    checkOutput("pulse_kind", {acc_done, acc_err}, monEntry.isErr ? 2'b01 : 2'b10);
                    checkOutput("pulse_cycle", cyc, monEntry.cyc);
                    checkOutput("pulse_code", err_code, monEntry.code);
                    checkOutput("pulse_ch", active_ch, monEntry.ch);
                    checkOutput("pulse_enable", acc_enable, '0);
                end
            end
        end
    end

    // Reference model. The channel's rd level is high for steps r..d-1 and its
    // wr level for steps w..d-1. A level driven at step k is seen at edge k+1.
    // Each waiting phase starts with the edge that enters it and gives up TMO
    // edges later. Release is first checked the edge after it is entered.
    function automatic plan_t predict(input int opc, input int r, input int w,
                                      input int dRel, input bit hold);
        plan_t p;
        int    e;
        int    x;
        p.kind = 0; p.code = 2'b00; p.pulse = -1; p.relPulse = -1;
        p.d = 0; p.endStep = 0; p.enChk = -1;
        if (opc == 0) return p;
        if (opc > NUM_ACC) begin
            p.kind = 2; p.code = 2'b01; p.pulse = 0; p.endStep = 1;
            return p;
        end
        if (r + 1 >= TMO) begin
            p.kind = 2; p.code = 2'b10; p.pulse = TMO; p.enChk = TMO - 1;
            p.endStep = TMO + 2;
            return p;
        end
        e = r + 1;
        x = (w + 1 > e + 1) ? w + 1 : e + 1;
        if (x - e >= TMO) begin
            p.kind = 2; p.code = 2'b11; p.pulse = e + TMO; p.enChk = e + TMO - 1;
            p.d = p.pulse + dRel;
            p.endStep = (p.d + 1 > p.pulse + 2) ? p.d + 1 : p.pulse + 2;
            return p;
        end
        p.kind = 1; p.code = 2'b00; p.pulse = x; p.enChk = x - 1;
        if (hold) begin
            p.relPulse = x + 1 + TMO;
            p.d = p.relPulse;
            p.endStep = p.relPulse + 1;
        end else begin
            p.d = x + dRel;
            p.endStep = (p.d + 1 > x + 2) ? p.d + 1 : x + 2;
        end
        return p;
    endfunction

    task automatic applyStimulus(input int opc, input int r, input int w, input int dRel,
                                 input bit hold, input bit preset, input bit earlyNext,
                                 input bit noise);
        plan_t              p;
        pulse_t             ent;
        bit                 legal;
        int                 ch;
        int                 base;
        int                 waitCnt;
        logic [CH_W-1:0]    expCh;
        logic [INSTR_W-1:0] iw;
        logic [NUM_ACC-1:0] own;
        logic [NUM_ACC-1:0] rdv;
        logic [NUM_ACC-1:0] wrv;

        p     = predict(opc, r, w, dRel, hold);
        legal = (opc >= 1) && (opc <= NUM_ACC);
        ch    = legal ? opc - 1 : 0;
        own   = legal ? (NUM_ACC'(1) << ch) : '0;
        expCh = legal ? CH_W'(ch) : mdlCh;

        waitCnt = 0;
        while (!instr_ready && waitCnt < 60) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("ready_before_issue", instr_ready, 1'b1);
        if (!instr_ready) return;

        iw = $urandom;
        iw[OPC_W-1:0] = OPC_W'(opc);
        instruction = iw;
        instr_valid = 1'b1;
        if (preset) begin
            rd_done = own;
            wr_done = own;
        end
        base = cyc + 1;
        if (p.kind != 0) begin
            ent.isErr = (p.kind == 2); ent.code = p.code; ent.ch = expCh; ent.cyc = base + p.pulse;
            expQ.push_back(ent);
        end
        if (p.relPulse >= 0) begin
            ent.isErr = 1'b1; ent.code = 2'b11; ent.ch = expCh; ent.cyc = base + p.relPulse;
            expQ.push_back(ent);
        end

        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k <= p.endStep; k++) begin
            instr_valid = earlyNext && (k >= p.pulse + 1) && (k <= p.d - 1);
            if (k == 0) begin
                checkOutput("enable_after_accept", acc_enable, own);
                checkOutput("ch_after_accept", active_ch, expCh);
                checkOutput("code_after_accept", err_code,
                            (opc == 0) ? mdlErr : (legal ? 2'b00 : 2'b01));
            end
            if (instr_valid) checkOutput("ready_while_releasing", instr_ready, 1'b0);
            if (p.endStep > 0 && k == p.endStep - 1) checkOutput("busy_in_op", busy, 1'b1);
            if (k == p.endStep) checkOutput("idle_after_op", busy, 1'b0);
            if (k == p.enChk) checkOutput("enable_held", acc_enable, own);
            rdv = noise ? NUM_ACC'($urandom) : '0;
            wrv = noise ? NUM_ACC'($urandom) : '0;
            rdv = (rdv & ~own) | ((k >= r && k < p.d) ? own : '0);
            wrv = (wrv & ~own) | ((k >= w && k < p.d) ? own : '0);
            rd_done = rdv;
            wr_done = wrv;
            if (k < p.endStep) @(negedge clk);
        end
        rd_done = '0;
        wr_done = '0;
        instr_valid = 1'b0;
        if (legal) mdlCh = CH_W'(ch);
        if (opc != 0) mdlErr = (p.relPulse >= 0) ? 2'b11 : p.code;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: simulation did not end (cycle %0d)", cyc);
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int opc, mode, r, w, dRel;
        bit hold, preset;

        reset       = 1'b0;
        instr_valid = 1'b0;
        instruction = '0;
        rd_done     = '0;
        wr_done     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_enable", acc_enable, '0);
        checkOutput("reset_pulses", {acc_done, acc_err}, 2'b00);
        checkOutput("reset_code", err_code, 2'b00);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_ready", instr_ready, 1'b1);
        checkOutput("reset_ch", active_ch, '0);
        reset = 1'b1;
        monOn = 1'b1;
        @(negedge clk);

        $display("[TB] T1 FFT with delayed dones");
        applyStimulus(1, 3, 7, 2, 0, 0, 0, 0);

        $display("[TB] T2 IIR with sticky dones and an early next instruction");
        applyStimulus(3, 0, 0, 3, 0, 1, 1, 0);
        applyStimulus(3, 1, 2, 0, 0, 0, 0, 0);

        $display("[TB] T3 illegal opcodes");
        applyStimulus(5, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(7, 0, 0, 0, 0, 0, 0, 1);

        $display("[TB] T4 watchdog: read, write and release timeouts");
        applyStimulus(2, NEVER, NEVER, 0, 0, 0, 0, 0);
        applyStimulus(2, 2, NEVER, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] T5 cross-channel dones ignored");
        applyStimulus(1, NEVER, NEVER, 0, 0, 0, 0, 1);

        $display("[TB] T6 reset during WRITE");
        instruction = 32'h0000_0002;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        rd_done = 3'b010;
        repeat (3) @(negedge clk);
        checkOutput("t6_enable_in_write", acc_enable, 3'b010);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        rd_done = '0;
        checkOutput("t6_enable", acc_enable, '0);
        checkOutput("t6_pulses", {acc_done, acc_err}, 2'b00);
        checkOutput("t6_code", err_code, 2'b00);
        checkOutput("t6_busy", busy, 1'b0);
        checkOutput("t6_ch", active_ch, '0);
        mdlErr = 2'b00;
        mdlCh  = '0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            opc    = $urandom_range(0, 7);
            mode   = $urandom_range(0, 5);
            r      = $urandom_range(0, TMO - 2);
            w      = $urandom_range(0, r + 6);
            dRel   = $urandom_range(0, 3);
            hold   = 1'b0;
            preset = 1'b0;
            case (mode)
                3: begin r = NEVER; w = NEVER; end
                4: w = NEVER;
                5: hold = 1'b1;
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        preset = 1'b1; r = 0; w = 0;
                    end
                end
            endcase
            applyStimulus(opc, r, w, dRel, hold, preset, 1'b0, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        monOn = 1'b0;
        checkOutput("pulses_outstanding", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
